// File: rtl/exmem_stage.sv
// EX/MEM pipeline stage: buffers ALU beats and owns the committed status register.
// Define EXMEM_SKID_EN for a two-entry skid buffer with registered in_ready.
module exmem_stage #(
   parameter int DATA_WIDTH   = 32,
   parameter int STATUS_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_result,
   input  logic [STATUS_WIDTH-1:0] in_status,
   input  logic                    in_set_flags,
   input  logic [4:0]              in_rd,
   input  logic                    in_regwrite,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_result,
   output logic [4:0]              out_rd,
   output logic                    out_regwrite,
   output logic [STATUS_WIDTH-1:0] status_q
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic [4:0]            rd;
      logic                  regwrite;
   } entry_t;

   entry_t                  e0_q, e0_d, in_e;
   logic [1:0]              cnt_q, cnt_d;
   logic [STATUS_WIDTH-1:0] status_d;
   logic                    push, pop;

   assign in_e      = '{result: in_result, rd: in_rd, regwrite: in_regwrite};
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_valid = (cnt_q != 2'd0);

   assign out_result   = e0_q.result;
   assign out_rd       = e0_q.rd;
   assign out_regwrite = e0_q.regwrite;

`ifdef EXMEM_SKID_EN
   entry_t e1_q, e1_d;
   logic   rdy_q, rdy_d;

   // Gate with rst_n so the stage never looks ready while held in reset.
   assign in_ready = rst_n && rdy_q;

   always_comb begin
      e0_d     = e0_q;
      e1_d     = e1_q;
      cnt_d    = cnt_q;
      status_d = status_q;
      if (pop) begin
         e0_d  = e1_q;
         cnt_d = cnt_q - 2'd1;
      end
      if (push) begin
         if (cnt_d == 2'd0) e0_d = in_e;
         else               e1_d = in_e;
         cnt_d = cnt_d + 2'd1;
         if (in_set_flags && !flush) status_d = in_status;
      end
      if (flush) cnt_d = 2'd0;
      rdy_d = (cnt_d != 2'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e1_q  <= '0;
         rdy_q <= 1'b1;
      end else begin
         e1_q  <= e1_d;
         rdy_q <= rdy_d;
      end
   end
`else
   assign in_ready = rst_n && (!out_valid || out_ready);

   always_comb begin
      e0_d     = e0_q;
      cnt_d    = cnt_q;
      status_d = status_q;
      if (pop) cnt_d = cnt_q - 2'd1;
      if (push) begin
         e0_d  = in_e;
         cnt_d = cnt_d + 2'd1;
         if (in_set_flags && !flush) status_d = in_status;
      end
      if (flush) cnt_d = 2'd0;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q     <= '0;
         cnt_q    <= 2'd0;
         status_q <= '0;
      end else begin
         e0_q     <= e0_d;
         cnt_q    <= cnt_d;
         status_q <= status_d;
      end
   end

endmodule

// File: tb/tb_exmem_stage.sv
// Scoreboard bench for exmem_stage; expected beats are queued on acceptance.
// Works for both the single-entry and EXMEM_SKID_EN builds.
module tb_exmem_stage;

   typedef logic [37:0] beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [3:0]  in_status;
   logic        in_set_flags;
   logic [4:0]  in_rd;
   logic        in_regwrite;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_regwrite;
   logic [3:0]  status_q;

   int    tests = 0;
   int    fails = 0;
   beat_t sb[$];
   logic [3:0] mstat = 4'h0;
   bit    stall_prev = 1'b0;
   beat_t prev_beat = '0;

`ifdef EXMEM_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   exmem_stage #(.DATA_WIDTH(32), .STATUS_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_status(in_status),
      .in_set_flags(in_set_flags), .in_rd(in_rd),
      .in_regwrite(in_regwrite), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_rd(out_rd),
      .out_regwrite(out_regwrite), .status_q(status_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: emission happens at the next posedge when valid&&ready here.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (stall_prev)
            chk("hold", {out_result, out_rd, out_regwrite}, prev_beat);
         if (out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", {out_result, out_rd, out_regwrite}, 0);
            end else begin
               chk("out_beat", {out_result, out_rd, out_regwrite},
                   sb.pop_front());
            end
         end
      end
      stall_prev = rst_n && out_valid && !out_ready;
      prev_beat  = {out_result, out_rd, out_regwrite};
   end

   task automatic drive(input logic [31:0] d, input logic [4:0] rd,
                        input logic rw, input logic sf,
                        input logic [3:0] st, input logic fl);
      int n = 0;
      bit acc = 1'b0;
      in_valid = 1'b1; in_result = d; in_rd = rd; in_regwrite = rw;
      in_set_flags = sf; in_status = st; flush = fl;
      while (!acc && n < 20) begin
         @(negedge clk);
         acc = in_ready;
         if (acc && !fl) begin
            sb.push_back({d, rd, rw});
            if (sf) mstat = st;
         end
         @(posedge clk);
         if (fl) sb.delete();
         #1;
         n++;
      end
      in_valid = 1'b0; in_set_flags = 1'b0; flush = 1'b0;
      if (!acc) chk("accept_timeout", 0, 1);
   endtask

   task automatic flush_only();
      flush = 1'b1;
      @(posedge clk);
      sb.delete();
      #1;
      flush = 1'b0;
   endtask

   initial begin
      logic [31:0] vals [3];
      int idx;
      int low;
      vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3;
      rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_status = '0;
      in_set_flags = 1'b0; in_rd = '0; in_regwrite = 1'b0;
      flush = 1'b0; out_ready = 1'b0;
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_fields", {out_result, out_rd, out_regwrite}, 0);
      chk("rst_status", status_q, 0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      chk("ready_after_rst", in_ready, 1);

      out_ready = 1'b1;
      drive(32'h0000000F, 5'd3, 1'b1, 1'b0, 4'h0, 1'b0);
      chk("lat_valid", out_valid, 1);
      chk("lat_result", out_result, 32'hF);
      chk("lat_rd", out_rd, 3);
      tick();

      out_ready = 1'b0;
      drive(32'hA5, 5'd7, 1'b1, 1'b1, 4'b0100, 1'b0);
      chk("z_status", status_q, 4'b0100);
      chk("z_valid", out_valid, 1);
      tick();
      chk("z_stall_valid", out_valid, 1);
      out_ready = 1'b1;
      tick(); tick();

      out_ready = 1'b0;
      idx = 0;
      in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'd9;
      for (int c = 0; c < 5; c++) begin
         in_result = vals[idx < 3 ? idx : 2];
         in_valid = (idx < 3);
         @(negedge clk);
         if (in_valid && in_ready) begin
            sb.push_back({in_result, in_rd, in_regwrite});
            idx++;
         end
         tick();
      end
      chk("stall_accepts", idx, DEPTH);
      out_ready = 1'b1;
      for (int c = 0; c < 10 && idx < 3; c++) begin
         in_result = vals[idx]; in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) begin
            sb.push_back({in_result, in_rd, in_regwrite});
            idx++;
         end
         tick();
      end
      in_valid = 1'b0;
      chk("stall_all_accepted", idx, 3);
      tick(); tick(); tick();

      drive(32'hDEAD, 5'd1, 1'b1, 1'b1, 4'hF, 1'b1);
      chk("flush_acc_valid", out_valid, 0);
      chk("flush_acc_status", status_q, mstat);

      out_ready = 1'b0;
      drive(32'h55, 5'd2, 1'b1, 1'b0, 4'h0, 1'b0);
      flush_only();
      chk("flush_buf_valid", out_valid, 0);

      drive(32'h66, 5'd4, 1'b0, 1'b0, 4'h0, 1'b0);
      out_ready = 1'b1;
      flush_only();
      chk("flush_emit_valid", out_valid, 0);
      chk("flush_emit_sb", sb.size(), 0);

      out_ready = 1'b0;
      drive(32'h77, 5'd5, 1'b1, 1'b1, 4'b1001, 1'b0);
`ifdef EXMEM_SKID_EN
      drive(32'h88, 5'd6, 1'b1, 1'b0, 4'h0, 1'b0);
`endif
      chk("pre_rst_status", status_q, 4'b1001);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_status", status_q, 0);
      chk("async_rst_fields", {out_result, out_rd, out_regwrite}, 0);
      sb.delete();
      mstat = 4'h0;
      tick(); tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick(); tick(); tick();
      chk("post_rst_no_beat", out_valid, 0);

      low = 0;
      for (int i = 0; i < 100; i++) begin
         bit acc = 1'b0;
         in_valid = 1'b1;
         in_result = $urandom;
         in_rd = 5'($urandom_range(0, 31));
         in_regwrite = 1'($urandom_range(0, 1));
         for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back({in_result, in_rd, in_regwrite});
            else low++;
            tick();
         end
      end
      in_valid = 1'b0;
      chk("stream_ready_low", low, 0);
      tick(); tick(); tick();
      chk("drain_empty", sb.size(), 0);
      chk("final_status", status_q, mstat);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
